lsu: RTL
========

# lsu

Load/store unit between the write-back stage and the data-memory bus of the three-stage RISC-V core. It takes the write-back stage's memory request (ALU address, store data, funct3), drives a single-outstanding req/ack bus with byte enables, and formats load data with sign or zero extension. It also holds the pipeline stalled while a transaction is in flight, and flags misaligned accesses and bus timeouts for the CSR/trap logic.

## Interface
- TIMEOUT, default 255: number of BUSY cycles without `bus_ack` before the transaction is abandoned.
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- mem_read  in  1  load request from the controller for the instruction in write-back
- mem_wr  in  1  store request from the controller
- funct3  in  3  instruction bits [14:12] of the write-back instruction
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value to store
- load_data  out  32  extended load result, registered
- load_valid  out  1  `load_data` is valid this cycle (RESP state, loads only)
- stall  out  1  hold fetch, decode and write-back registers
- misaligned  out  1  access is misaligned; no bus activity is issued
- bus_err  out  1  transaction timed out
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write
- bus_addr  out  32  word address; `{addr[31:2],2'b00}`
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned store data
- bus_ack  in  1  slave completes the transfer this cycle
- bus_rdata  in  32  read data; valid when `bus_ack` is high

## Operation
- A request (`req`) is `mem_read | mem_wr`. If both are high, the write wins and the read is ignored.
- Alignment rules:
  - Halfword (funct3[1:0]=01) requires `addr[0]=0`.
  - Word (10) requires `addr[1:0]=0`.
  - Byte accesses are always aligned.
  - funct3 values 011/110/111 are treated as word accesses.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Aligned `req`: latch `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, funct3 and `addr[1:0]`. Clear the timeout counter. Go to BUSY.
  - Misaligned `req`: `misaligned=1` combinationally, `stall=0`, remain in IDLE, no bus activity.
- BUSY:
  - `bus_req=1`. All bus outputs stay stable until `bus_ack`.
  - On `bus_ack`: for a load, capture the extended `bus_rdata` into `load_data`. Go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without `bus_ack`: set `bus_err` and `load_data=0`, go to RESP.
- RESP:
  - `stall=0`.
  - `load_valid=1` for a load without error.
  - `bus_err` stays high through RESP if set.
  - Always returns to IDLE. The request still present on the inputs in RESP belongs to the completing instruction and is not reissued.
- `stall = (IDLE & req & aligned) | BUSY`.
- Store lanes:
  - SB: `be = 4'b0001 << addr[1:0]`, data is the byte replicated ×4.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, data is the halfword replicated ×2.
  - SW: `be = 4'b1111`.
- Load lanes:
  - Byte/halfword is selected by the latched `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Loads drive `bus_be` the same way as stores, for observability.
- Reset (asynchronous, `rst` low):
  - State returns to IDLE and the counter clears.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `load_data`, `load_valid`, `bus_err` and `stall` all go to 0, including in the middle of a transaction.

## Timing
- Cycle 0: request accepted in IDLE, `stall=1`.
- Cycle 1: `bus_req=1`.
- Ack in cycle k≥1 → RESP in cycle k+1 with `load_data` valid. Minimum 2 stall cycles.
- An ack arriving in the same cycle `bus_req` first rises is legal.
- `bus_ack` seen while not in BUSY is ignored.
- Timeout: `bus_err` is asserted in the cycle after the TIMEOUT-th BUSY cycle.
- The counter is `$clog2(TIMEOUT+1)` bits and never wraps.
- `misaligned` is combinational in the same cycle as the request and costs no stall.

## Structure
- `lsu_pkg`:
  - state enum `lsu_state_e` (IDLE, BUSY, RESP)
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - bus width localparams
- Sub-module `lsu_align`: purely combinational. Store lane/byte-enable generation and load extract/extend. The FSM, counter and registers live in `lsu`.

## Test plan
- SW `addr=0x100`, `store_data=0xDEADBEEF`, ack after 3 cycles → `bus_we=1`, `bus_be=1111`, `bus_addr=0x100`, `stall` high for 4 cycles, RESP with `load_valid=0`.
- LB `addr=0x203`, `bus_rdata=0x80112233`, immediate ack → `load_data=0xFFFFFF80`. LBU on the same access → `0x00000080`.
- LH `addr=0x202`, `bus_rdata=0x8001ABCD` → `load_data=0xFFFF8001`. SH `addr=0x202` data `0x1234` → `be=1100`, `wdata=0x12341234`.
- LW `addr=0x102` → `misaligned=1` same cycle, `bus_req` stays 0, `stall=0`.
- LW, no ack, TIMEOUT=8 → `bus_req` drops after 8 BUSY cycles, `bus_err=1`, `load_data=0`, `stall` releases.
- `rst` driven low mid-BUSY → `bus_req` and `stall` go to 0 immediately. After release, a new SW issues normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings
// and the alignment rule used by both the datapath and the control.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // size is funct3[1:0]; 2'b11 falls into the word case with 2'b10.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            F3_B[1:0]: return 1'b1;
            F3_H[1:0]: return ~off[0];
            default:   return off == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data, and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] store_data,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_zext;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (st_size)
            F3_B[1:0]: begin
                be    = 4'b0001 << st_off;
                wdata = {4{store_data[7:0]}};
            end
            F3_H[1:0]: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_off)
            2'b01:   ld_byte = rdata[15:8];
            2'b10:   ld_byte = rdata[23:16];
            2'b11:   ld_byte = rdata[31:24];
            default: ;
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_zext = (ld_funct3 == F3_BU) || (ld_funct3 == F3_HU);
        case (ld_funct3[1:0])
            F3_B[1:0]: ldata = {{24{ld_byte[7] & ~ld_zext}}, ld_byte};
            F3_H[1:0]: ldata = {{16{ld_half[15] & ~ld_zext}}, ld_half};
            default:   ldata = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/ack data bus master with pipeline stall,
// misalignment detection and a bounded wait for the slave's acknowledge.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_wr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            stall,
    output logic            misaligned,
    output logic            bus_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             err_q, err_d;
    logic [XLEN-1:0]  ld_q, ld_d;
    logic             we_q;
    logic [XLEN-1:0]  addr_q, wdata_q;
    logic [BE_W-1:0]  be_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic            req, aligned, accept;
    logic [BE_W-1:0] be_n;
    logic [XLEN-1:0] wdata_n, ldata_ext;

    assign req     = mem_read | mem_wr;
    assign aligned = is_aligned(funct3[1:0], addr[1:0]);
    assign accept  = (state_q == IDLE) & req & aligned;

    lsu_align u_align (
        .st_size    (funct3[1:0]),
        .st_off     (addr[1:0]),
        .store_data (store_data),
        .be         (be_n),
        .wdata      (wdata_n),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .rdata      (bus_rdata),
        .ldata      (ldata_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        ld_d    = ld_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        ld_d = ldata_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    ld_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
        end
    end

    // Transaction attributes are frozen at acceptance so the bus stays stable while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else if (accept) begin
            we_q    <= mem_wr;
            addr_q  <= {addr[XLEN-1:2], 2'b00};
            be_q    <= be_n;
            wdata_q <= wdata_n;
            f3_q    <= funct3;
            off_q   <= addr[1:0];
        end
    end

    assign bus_req    = req_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_be     = be_q;
    assign bus_wdata  = wdata_q;
    assign bus_err    = err_q;
    assign load_data  = ld_q;
    assign load_valid = (state_q == RESP) & ~we_q & ~err_q;
    assign misaligned = (state_q == IDLE) & req & ~aligned;
    // Reset also masks the combinational accept term so stall drops while rst is held.
    assign stall      = rst & (accept | (state_q == BUSY));

endmodule
